// File: rtl/register_file.sv
// 32 x 32-bit register file for the ID stage: two bypassed read ports, one write-back port,
// a per-register pending-write scoreboard with a sticky error flag, and a registered debug read port.
module register_file #(
    parameter int SB_CNT_WIDTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  RegAdd_rs,
    input  logic [4:0]  RegAdd_rt,
    output logic [31:0] RegData_rs,
    output logic [31:0] RegData_rt,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_RegAdd,
    input  logic [31:0] WB_RegData,
    input  logic        Reserve_Valid,
    input  logic [4:0]  Reserve_Add,
    output logic        Busy_rs,
    output logic        Busy_rt,
    input  logic [4:0]  Debug_Add,
    output logic [31:0] Debug_Data,
    output logic        Sb_Error
);

    localparam logic [SB_CNT_WIDTH-1:0] CNT_MAX  = {SB_CNT_WIDTH{1'b1}};
    localparam logic [SB_CNT_WIDTH-1:0] CNT_ONE  = SB_CNT_WIDTH'(1);
    localparam logic [SB_CNT_WIDTH-1:0] CNT_ZERO = SB_CNT_WIDTH'(0);

    logic [31:0]             regs_q [32];
    logic [31:0]             regs_d [32];
    logic [SB_CNT_WIDTH-1:0] cnt_q  [32];
    logic [SB_CNT_WIDTH-1:0] cnt_d  [32];
    logic [31:0]             debug_data_q;
    logic [31:0]             debug_data_d;
    logic                    sb_error_q;
    logic                    sb_error_d;
    logic                    inc_s;
    logic                    dec_s;

    function automatic logic [31:0] bypass_read(
        input logic [4:0]  addr,
        input logic [31:0] stored,
        input logic        wb_en,
        input logic [4:0]  wb_add,
        input logic [31:0] wb_data
    );
        logic [31:0] value;
        if (addr == 5'd0) begin
            value = 32'd0;
        end else if (wb_en && (wb_add == addr)) begin
            value = wb_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // A single pending write that retires this very cycle is already covered by the bypass.
    function automatic logic busy_of(
        input logic [4:0]              addr,
        input logic [SB_CNT_WIDTH-1:0] cnt,
        input logic                    dec,
        input logic [4:0]              wb_add
    );
        logic busy;
        if (addr == 5'd0) begin
            busy = 1'b0;
        end else if (cnt > CNT_ONE) begin
            busy = 1'b1;
        end else if (cnt == CNT_ONE) begin
            busy = !(dec && (wb_add == addr));
        end else begin
            busy = 1'b0;
        end
        return busy;
    endfunction

    // Reservation and retirement qualifiers; register 0 never participates.
    always_comb begin
        inc_s = Reserve_Valid && (Reserve_Add != 5'd0);
        dec_s = WB_RegWrite && (WB_RegAdd != 5'd0);
    end

    // Combinational read ports, busy flags and the debug value to be captured.
    always_comb begin
        RegData_rs   = bypass_read(RegAdd_rs, regs_q[RegAdd_rs], WB_RegWrite, WB_RegAdd, WB_RegData);
        RegData_rt   = bypass_read(RegAdd_rt, regs_q[RegAdd_rt], WB_RegWrite, WB_RegAdd, WB_RegData);
        debug_data_d = bypass_read(Debug_Add, regs_q[Debug_Add], WB_RegWrite, WB_RegAdd, WB_RegData);
        Busy_rs      = busy_of(RegAdd_rs, cnt_q[RegAdd_rs], dec_s, WB_RegAdd);
        Busy_rt      = busy_of(RegAdd_rt, cnt_q[RegAdd_rt], dec_s, WB_RegAdd);
    end

    // Next-state storage: write-back into any register except r0.
    always_comb begin
        regs_d = regs_q;
        if (dec_s) begin
            regs_d[WB_RegAdd] = WB_RegData;
        end else begin
            regs_d[0] = 32'd0;
        end
    end

    // Scoreboard counters: a reserve and retire hitting the same register cancel out.
    always_comb begin
        cnt_d      = cnt_q;
        sb_error_d = sb_error_q;
        for (int r = 1; r < 32; r++) begin
            if (inc_s && (Reserve_Add == 5'(r)) && !(dec_s && (WB_RegAdd == 5'(r)))) begin
                if (cnt_q[r] == CNT_MAX) begin
                    sb_error_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
            end else if (dec_s && (WB_RegAdd == 5'(r)) && !(inc_s && (Reserve_Add == 5'(r)))) begin
                if (cnt_q[r] == CNT_ZERO) begin
                    sb_error_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] - CNT_ONE;
                end
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
        cnt_d[0] = CNT_ZERO;
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < 32; r++) begin
                regs_q[r] <= 32'd0;
                cnt_q[r]  <= CNT_ZERO;
            end
            debug_data_q <= 32'd0;
            sb_error_q   <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            cnt_q        <= cnt_d;
            debug_data_q <= debug_data_d;
            sb_error_q   <= sb_error_d;
        end
    end

    assign Debug_Data = debug_data_q;
    assign Sb_Error   = sb_error_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: a driver pushes model expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_register_file;

    localparam int SB_W    = 2;
    localparam int CNT_LIM = (1 << SB_W) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  RegAdd_rs, RegAdd_rt, WB_RegAdd, Reserve_Add, Debug_Add;
    logic [31:0] RegData_rs, RegData_rt, WB_RegData, Debug_Data;
    logic        WB_RegWrite, Reserve_Valid, Busy_rs, Busy_rt, Sb_Error;

    always #5 clock = ~clock;

    register_file #(.SB_CNT_WIDTH(SB_W)) dut (
        .clock(clock), .reset(reset),
        .RegAdd_rs(RegAdd_rs), .RegAdd_rt(RegAdd_rt),
        .RegData_rs(RegData_rs), .RegData_rt(RegData_rt),
        .WB_RegWrite(WB_RegWrite), .WB_RegAdd(WB_RegAdd), .WB_RegData(WB_RegData),
        .Reserve_Valid(Reserve_Valid), .Reserve_Add(Reserve_Add),
        .Busy_rs(Busy_rs), .Busy_rt(Busy_rt),
        .Debug_Add(Debug_Add), .Debug_Data(Debug_Data), .Sb_Error(Sb_Error)
    );

    typedef struct {
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] dbg;
        logic        busy_rs;
        logic        busy_rt;
        logic        err;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    // Reference model: plain register array and integer pending counts.
    logic [31:0] m_reg [32];
    int          m_cnt [32];
    logic        m_err;
    logic [31:0] m_dbg;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (WB_RegWrite && WB_RegAdd == a) return WB_RegData;
        return m_reg[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a);
        int pending;
        if (a == 5'd0) return 1'b0;
        pending = m_cnt[a];
        if (WB_RegWrite && WB_RegAdd == a) pending = pending - 1;
        return pending > 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'd0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
        m_dbg = 32'd0;
    endtask

    // Model state advance on each rising edge outside reset.
    always @(posedge clock) begin
        if (!reset) begin
            logic inc, dec;
            m_dbg = m_read(Debug_Add);
            inc = Reserve_Valid && Reserve_Add != 5'd0;
            dec = WB_RegWrite && WB_RegAdd != 5'd0;
            if (!(inc && dec && Reserve_Add == WB_RegAdd)) begin
                if (inc) begin
                    if (m_cnt[Reserve_Add] == CNT_LIM) m_err = 1'b1;
                    else m_cnt[Reserve_Add] = m_cnt[Reserve_Add] + 1;
                end
                if (dec) begin
                    if (m_cnt[WB_RegAdd] == 0) m_err = 1'b1;
                    else m_cnt[WB_RegAdd] = m_cnt[WB_RegAdd] - 1;
                end
            end
            if (dec) m_reg[WB_RegAdd] = WB_RegData;
        end
    end

    task automatic push_expect(input string tag);
        exp_t e;
        e.rs_data = m_read(RegAdd_rs);
        e.rt_data = m_read(RegAdd_rt);
        e.busy_rs = m_busy(RegAdd_rs);
        e.busy_rt = m_busy(RegAdd_rt);
        e.dbg     = m_dbg;
        e.err     = m_err;
        e.tag     = tag;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input string name, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s %s: got %h, expected %h", tag, name, got, want);
        end
    endtask

    // Monitor: compare whatever expectation is pending against the settled outputs.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.tag, "RegData_rs", RegData_rs, e.rs_data);
            check(e.tag, "RegData_rt", RegData_rt, e.rt_data);
            check(e.tag, "Busy_rs", {31'd0, Busy_rs}, {31'd0, e.busy_rs});
            check(e.tag, "Busy_rt", {31'd0, Busy_rt}, {31'd0, e.busy_rt});
            check(e.tag, "Debug_Data", Debug_Data, e.dbg);
            check(e.tag, "Sb_Error", {31'd0, Sb_Error}, {31'd0, e.err});
        end
    end

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic rv, input logic [4:0] ra,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] da,
                        input string tag);
        WB_RegWrite   = we;
        WB_RegAdd     = wa;
        WB_RegData    = wd;
        Reserve_Valid = rv;
        Reserve_Add   = ra;
        RegAdd_rs     = rs;
        RegAdd_rt     = rt;
        Debug_Add     = da;
        push_expect(tag);
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset asserted one unit after an edge, i.e. between clock edges.
    task automatic mid_reset(input string tag);
        WB_RegWrite   = 1'b0;
        Reserve_Valid = 1'b0;
        reset         = 1'b1;
        model_reset();
        push_expect(tag);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        WB_RegWrite = 1'b0; WB_RegAdd = 5'd0; WB_RegData = 32'd0;
        Reserve_Valid = 1'b0; Reserve_Add = 5'd0;
        RegAdd_rs = 5'd0; RegAdd_rt = 5'd0; Debug_Add = 5'd0;
        model_reset();
        @(posedge clock);
        #1;
        RegAdd_rs = 5'd5;
        RegAdd_rt = 5'd31;
        push_expect("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;

        // write and read-back, r0 discard
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd0, 5'd0, "res_r5");
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd5, 5'd0, "res_r7");
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd7, 5'd0, "wr_r5");
        step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd0, 5'd0, "wr_r0");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd5, "rd_r5");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0, 5'd5, "dbg_r5");
        // same-cycle bypass on both ports
        step(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd7, 5'd5, "byp_r7");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7, 5'd5, "rd_r7");
        // single pending write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3, 5'd5, "res_r3");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd5, "busy_r3");
        step(1'b1, 5'd3, 32'h00000055, 1'b0, 5'd0, 5'd3, 5'd3, 5'd5, "ret_r3");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3, 5'd5, "idle_r3");
        // reserve and retire of the same register cancel
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 5'd4, 5'd0, 5'd5, "res_r4");
        step(1'b1, 5'd4, 32'h00000044, 1'b1, 5'd4, 5'd4, 5'd0, 5'd5, "resret_r4");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd0, 5'd5, "hold_r4");
        step(1'b1, 5'd4, 32'h00000045, 1'b0, 5'd0, 5'd4, 5'd0, 5'd5, "ret_r4");
        // reservation of r0 is ignored
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0, 5'd4, 5'd5, "res_r0");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd4, 5'd5, "idle_r0");
        // saturation of r9
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd5, "res_r9");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd5, "full_r9");
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd9, 5'd5, "ovf_r9");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd5, "err_r9");
        for (int i = 0; i < 3; i++) step(1'b1, 5'd9, 32'h900 + i, 1'b0, 5'd0, 5'd9, 5'd9, 5'd5, "ret_r9");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd9, 5'd5, "idle_r9");
        // mid-operation reset with pending work outstanding
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 5'd10, 5'd5, 5'd5, "res_r10");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd5, 5'd5, "pre_rst");
        mid_reset("mid_rst");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd10, 5'd5, "post_rst");
        // underflow
        step(1'b1, 5'd6, 32'h00000066, 1'b0, 5'd0, 5'd6, 5'd0, 5'd6, "uf_r6");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd6, "uf_err");

        // randomized traffic over a narrow address window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, ra, rs, rt, da;
            if (n % 100 == 99) begin
                mid_reset("rand_rst");
            end else begin
                wa = 5'($urandom_range(0, 7));
                ra = 5'($urandom_range(0, 7));
                rs = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
                rt = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 7));
                da = 5'($urandom_range(0, 7));
                step(1'($urandom_range(0, 1)), wa, 32'($urandom), 1'($urandom_range(0, 1)), ra, rs, rt, da, "rand");
            end
        end

        repeat (4) @(negedge clock);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Register file and hazard scoreboard serving the ID stage. It answers the rs/rt read requests that ID issues from the instruction fields, and accepts the single write-back from WB with same-cycle bypass. A per-register pending-write scoreboard lets ID detect operands that are not yet available. A registered debug port exposes any register for the Spartan3E board display.

## Interface

Parameters:
- `SB_CNT_WIDTH`, default 2: width of each per-register pending-write counter. The maximum pending count is 2^SB_CNT_WIDTH − 1, which is 3 by default.

Ports (clock and reset first):
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `RegAdd_rs`  in  5  read address A, from ID.
- `RegAdd_rt`  in  5  read address B, from ID.
- `RegData_rs`  out  32  read data A (combinational).
- `RegData_rt`  out  32  read data B (combinational).
- `WB_RegWrite`  in  1  write-back enable; also retires one pending write.
- `WB_RegAdd`  in  5  write-back destination.
- `WB_RegData`  in  32  write-back data.
- `Reserve_Valid`  in  1  ID issues an instruction that will write `Reserve_Add`.
- `Reserve_Add`  in  5  destination being reserved.
- `Busy_rs`  out  1  rs has an unretired pending write not covered by the bypass.
- `Busy_rt`  out  1  rt has an unretired pending write not covered by the bypass.
- `Debug_Add`  in  5  debug read address.
- `Debug_Data`  out  32  registered debug read data.
- `Sb_Error`  out  1  sticky scoreboard error flag.

## Operation

- Storage: 32 × 32-bit registers. Register 0 always reads 0. Writes to register 0 are discarded.
- Write: on the rising edge, if `WB_RegWrite` is high and `WB_RegAdd` ≠ 0, then reg[`WB_RegAdd`] ← `WB_RegData`.
- Read, per port with address `a`:
  - `a` = 0 → 0.
  - Else if `WB_RegWrite` is high and `WB_RegAdd` = `a` → `WB_RegData` (write-through bypass).
  - Else → reg[`a`].
- Scoreboard: one counter `cnt[r]` of width `SB_CNT_WIDTH` per register r = 1..31. `cnt[0]` is held at 0.
- Reservation and retirement terms:
  - `inc` = `Reserve_Valid` and `Reserve_Add` ≠ 0.
  - `dec` = `WB_RegWrite` and `WB_RegAdd` ≠ 0.
- Counter update per register r on the rising edge:
  - `inc` only, targeting r → `cnt[r]`+1. If `cnt[r]` is already at maximum: hold the value and set `Sb_Error`.
  - `dec` only, targeting r → `cnt[r]`−1. If `cnt[r]` = 0: hold 0 and set `Sb_Error`.
  - Both target the same r → `cnt[r]` unchanged, no error.
  - `inc` and `dec` target different registers → each is applied independently.
- `Busy_x` for address `a`:
  - 0 if `a` = 0.
  - Else 1 when `cnt[a]` ≥ 2.
  - Else 1 when `cnt[a]` = 1 and not (`dec` and `WB_RegAdd` = `a`).
  - A reservation in the current cycle does not affect Busy until the next cycle.
- `Sb_Error` is sticky; only reset clears it.
- Debug: on the rising edge, `Debug_Data` ← the bypassed read value of `Debug_Add`, using the same rules as the read ports.

## Timing

- Reset (asynchronous, active-high):
  - All 32 registers = 0, all `cnt` = 0, `Debug_Data` = 0, `Sb_Error` = 0.
  - Consequently `RegData_rs` and `RegData_rt` = 0 and `Busy_rs` and `Busy_rt` = 0 (unless the bypass is active).
  - Assertion mid-operation clears state immediately, regardless of the clock. Inputs are ignored until reset deasserts.
- Read ports, Busy outputs: zero-cycle latency, combinational from the address and WB inputs.
- Write: visible through the bypass in the same cycle. Visible from storage from the cycle after the edge.
- Scoreboard: a reservation at edge N makes Busy high from cycle N+1. A retirement is reflected by the bypass in its own cycle.
- `Debug_Data`: 1-cycle latency.
- Simultaneous events:
  - `rs` = `rt` = `WB_RegAdd`: both ports bypass.
  - Reserve and retire of the same register in one cycle: the counter nets to zero change.

## Test plan

- Reset, then write: write 0xDEADBEEF to r5, 0x12345678 to r0. Next cycle read rs=5, rt=0 → 0xDEADBEEF, 0x00000000.
- Bypass: in the same cycle, `WB_RegWrite`=1, `WB_RegAdd`=7, `WB_RegData`=0xA5A5A5A5, rs=rt=7 → both outputs 0xA5A5A5A5. Next cycle with WB idle, r7 still reads 0xA5A5A5A5.
- Scoreboard, single pending write:
  - Reserve r3 → next cycle `Busy_rs`=1 (rs=3).
  - Retire r3 with data 0x55 → `Busy_rs`=0 and `RegData_rs`=0x55 in that same cycle.
  - Afterwards `cnt[3]`=0.
- Multiple pending writes and saturation:
  - Reserve r9 three times → `cnt`=3, Busy=1.
  - A fourth reserve → `Sb_Error`=1 and `cnt` stays at 3.
  - Three retires → Busy drops at the third retire.
- Simultaneous and underflow cases:
  - Reserve and retire r4 in one cycle with `cnt[4]`=1 → `cnt[4]` stays 1, no error.
  - Retire r6 with `cnt[6]`=0 → `Sb_Error`=1.
  - Reserve r0 → no effect on any counter or Busy.
- Debug and mid-operation reset:
  - Set `Debug_Add`=5 → `Debug_Data`=0xDEADBEEF one cycle later.
  - Assert `reset` between clock edges → `Debug_Data`, `Sb_Error` and all Busy outputs go to 0 immediately. r5 then reads 0.
